// File: rtl/inst_fetch_pkg.sv
// Shared core constants and the fetch-buffer entry type. The instruction memory
// uses the same package, so it and the fetch path agree on instruction and address widths.
package inst_fetch_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INST_WIDTH = 48;
    localparam int INST_BYTES = 6;
    localparam int BUF_DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Sequential successor address; wraps modulo 2^32 by construction.
    function automatic logic [ADDR_WIDTH-1:0] next_pc(input logic [ADDR_WIDTH-1:0] addr);
        return addr + ADDR_WIDTH'(INST_BYTES);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect strobe and decode handshake.
// The fetch unit is the master; memory, decode and redirect logic form the slave side.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic                  o_imem_en;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [INST_WIDTH-1:0] i_imem_data;
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_redirect_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [INST_WIDTH-1:0] o_inst;
    logic [ADDR_WIDTH-1:0] o_pc;

    modport master (
        output o_imem_en, o_imem_addr, o_valid, o_inst, o_pc,
        input  i_imem_data, i_redirect, i_redirect_pc, i_ready
    );

    modport slave (
        input  o_imem_en, o_imem_addr, o_valid, o_inst, o_pc,
        output i_imem_data, i_redirect, i_redirect_pc, i_ready
    );

endinterface

// File: rtl/inst_fetch_buf.sv
// Two-entry in-order {pc, inst} buffer with push, pop and flush.
// The head is read straight from a slot register, so it has no path from the push data.
module inst_fetch_buf
    import inst_fetch_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    logic         pop_ok;
    logic         push_ok;
    logic         write_en;
    fetch_entry_t slot [BUF_DEPTH];

    assign pop_ok   = i_pop && (count_reg != 2'd0);
    // A full buffer accepts a push only when the head leaves in the same cycle.
    assign push_ok  = i_push && ((count_reg != 2'd2) || pop_ok);
    assign write_en = push_ok && !i_flush;

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            fetch_entry_t entry_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    entry_reg <= '0;
                end else if (write_en && (int'(wr_ptr_reg) == gi)) begin
                    entry_reg <= i_push_entry;
                end
            end

            assign slot[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            if (push_ok) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            count_reg <= count_reg + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign o_count = count_reg;
    assign o_head  = slot[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues sequential 6-byte reads, buffers responses in a 2-entry
// queue and offers them to decode; a redirect flushes the queue and refetches.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    inst_fetch_if.master  bus
);

    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] inflight_addr_reg;
    logic                  inflight_reg;

    logic [1:0]            buf_count;
    fetch_entry_t          buf_head;
    fetch_entry_t          push_entry;

    logic                  redirect;
    logic                  valid;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] req_addr;

    always_comb begin
        redirect  = bus.i_redirect && !i_rst;
        valid     = !i_rst && (buf_count != 2'd0) && !redirect;
        pop       = valid && bus.i_ready;
        // Slots already claimed once this cycle's transfer is accounted for.
        occupancy = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
        issue     = !i_rst && (redirect || (occupancy < 3'd2));
        req_addr  = redirect ? bus.i_redirect_pc : pc_reg;
        // A response returning in a redirect cycle belongs to the abandoned stream.
        push      = inflight_reg && !redirect && !i_rst;
    end

    assign push_entry = '{pc: inflight_addr_reg, inst: bus.i_imem_data};

    inst_fetch_buf u_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (push),
        .i_push_entry (push_entry),
        .i_pop        (pop),
        .i_flush      (redirect),
        .o_count      (buf_count),
        .o_head       (buf_head)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg            <= RESET_PC;
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg            <= next_pc(req_addr);
                inflight_addr_reg <= req_addr;
            end
        end
    end

    assign bus.o_imem_en   = issue;
    assign bus.o_imem_addr = req_addr;
    assign bus.o_valid     = valid;
    assign bus.o_inst      = i_rst ? '0 : buf_head.inst;
    assign bus.o_pc        = i_rst ? '0 : buf_head.pc;

endmodule
